// File: rtl/seq_match_logger.sv
// Hit logger for a sequence detector: counts match hits, timestamps each one with a
// free-running cycle counter, and queues the stamps in a first-word-fall-through FIFO.
module seq_match_logger #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             match,
  input  logic             rd_en,
  output logic [TS_W-1:0]  rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0]  r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic w_hit;
  logic w_pop;
  logic w_push;

  // Extra MSB on each pointer distinguishes full from empty when the addresses coincide.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign w_hit  = en & match;
  assign w_pop  = rd_en & ~empty;
  // A pop frees the slot in the same cycle, so a hit on a full FIFO still lands when popping.
  assign w_push = w_hit & (~full | w_pop);

  assign rd_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign count    = r_count;
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ts       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (en) begin
        r_ts <= r_ts + 1'b1;
      end
      if (w_hit && (r_count != '1)) begin
        r_count <= r_count + 1'b1;
      end
      if (w_hit && full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= r_ts;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_match_logger.sv
// Directed bench for seq_match_logger: fixed stimulus steps with hand-computed expectations.
module tb_seq_match_logger;

  logic       clk;
  logic       reset;
  logic       en;
  logic       match;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;

  int n_checks;
  int n_errs;

  seq_match_logger #(
    .TS_W  (8),
    .DEPTH (4),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .match    (match),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    match = 1'b0;
    rd_en = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;

    // Reset state
    do_reset();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // 1. Basic capture at ts=5
    en = 1'b1;
    cyc(5);
    match = 1'b1;
    cyc();
    match = 1'b0;
    chk("t1_empty", 32'(empty), 0);
    chk("t1_data", 32'(rd_data), 5);
    chk("t1_count", 32'(count), 1);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("t1_popped_empty", 32'(empty), 1);

    // 2. Overflow: hits at ts 10,12,14,16,18 with no reads
    do_reset();
    en = 1'b1;
    cyc(10);
    for (int k = 0; k < 5; k++) begin
      match = 1'b1;
      cyc();
      if (k == 3) chk("t2_full4", 32'(full), 1);
      match = 1'b0;
      cyc();
    end
    chk("t2_count", 32'(count), 5);
    chk("t2_ovf", 32'(overflow), 1);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain", 32'(rd_data), 32'(10 + 2 * k));
      rd_en = 1'b1;
      cyc();
    end
    rd_en = 1'b0;
    chk("t2_empty", 32'(empty), 1);

    // 3. Push and pop in the same cycle while full
    do_reset();
    en = 1'b1;
    cyc(10);
    for (int k = 0; k < 4; k++) begin
      match = 1'b1;
      cyc();
      match = 1'b0;
      cyc();
    end
    cyc(2);
    chk("t3_full_pre", 32'(full), 1);
    match = 1'b1;
    rd_en = 1'b1;
    cyc();
    match = 1'b0;
    rd_en = 1'b0;
    en    = 1'b0;
    chk("t3_head", 32'(rd_data), 12);
    chk("t3_full", 32'(full), 1);
    chk("t3_ovf", 32'(overflow), 0);
    chk("t3_count", 32'(count), 5);
    for (int k = 0; k < 4; k++) begin
      chk("t3_drain", 32'(rd_data), (k == 3) ? 32'd20 : 32'(12 + 2 * k));
      rd_en = 1'b1;
      cyc();
    end
    rd_en = 1'b0;
    chk("t3_empty", 32'(empty), 1);

    // 4. Counter saturation, then enable gating
    do_reset();
    en    = 1'b1;
    match = 1'b1;
    rd_en = 1'b1;
    cyc(20);
    rd_en = 1'b0;
    chk("t4_sat", 32'(count), 15);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_head", 32'(rd_data), 19);
    en = 1'b0;
    cyc(3);
    chk("t4_gate_count", 32'(count), 15);
    chk("t4_gate_empty", 32'(empty), 0);
    chk("t4_gate_head", 32'(rd_data), 19);
    en = 1'b1;
    cyc();
    en    = 1'b0;
    match = 1'b0;
    chk("t4_head_after", 32'(rd_data), 19);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("t4_ts_held", 32'(rd_data), 20);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("t4_empty", 32'(empty), 1);

    // 5. Timestamp wrap, then reads while empty
    do_reset();
    en = 1'b1;
    cyc(257);
    match = 1'b1;
    cyc();
    match = 1'b0;
    chk("t5_wrap", 32'(rd_data), 1);
    chk("t5_count", 32'(count), 1);
    rd_en = 1'b1;
    cyc();
    en = 1'b0;
    cyc(3);
    rd_en = 1'b0;
    chk("t5_er_empty", 32'(empty), 1);
    chk("t5_er_full", 32'(full), 0);
    chk("t5_er_count", 32'(count), 1);
    chk("t5_er_ovf", 32'(overflow), 0);
    en    = 1'b1;
    match = 1'b1;
    cyc();
    en    = 1'b0;
    match = 1'b0;
    chk("t5_after_er", 32'(rd_data), 3);
    chk("t5_after_er_empty", 32'(empty), 0);

    // 6. Reset while full with overflow set
    do_reset();
    en    = 1'b1;
    match = 1'b1;
    cyc(9);
    chk("t6_pre_full", 32'(full), 1);
    chk("t6_pre_ovf", 32'(overflow), 1);
    chk("t6_pre_count", 32'(count), 9);
    reset = 1'b1;
    rd_en = 1'b1;
    cyc();
    reset = 1'b0;
    en    = 1'b0;
    match = 1'b0;
    rd_en = 1'b0;
    chk("t6_empty", 32'(empty), 1);
    chk("t6_full", 32'(full), 0);
    chk("t6_count", 32'(count), 0);
    chk("t6_ovf", 32'(overflow), 0);
    en    = 1'b1;
    match = 1'b1;
    cyc();
    en    = 1'b0;
    match = 1'b0;
    chk("t6_stamp0", 32'(rd_data), 0);
    chk("t6_count1", 32'(count), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/seq_match_logger.md
Name: seq_match_logger

Overview:
Downstream consumer of the sequence detector's one-bit match output. Counts detector hits and stamps each hit with a free-running cycle timestamp. Stamps are buffered in a small first-word-fall-through FIFO so a slower readout stage can drain them.

Parameters:
TS_W, 8, width of the free-running timestamp counter and of each FIFO entry
DEPTH, 4, FIFO entries (power of two, >= 2)
CNT_W, 4, width of the saturating hit counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  logging enable; gates timestamp advance and match capture
match  input  1  detector output; each cycle sampled high = one hit
rd_en  input  1  pop request from readout stage
rd_data  output  TS_W  timestamp at FIFO head (valid when empty=0)
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds DEPTH entries
count  output  CNT_W  total hits seen since reset, saturating
overflow  output  1  sticky: a hit arrived while FIFO full with no pop

Behaviour:
- Single clock domain; all state updates on rising clk edge.
- Reset is synchronous and active-high. While reset=1 at an edge, the following take effect:
  - ts=0, count=0, overflow=0.
  - FIFO pointers cleared, so empty=1 and full=0.
  - rd_data=0.
- Reset has priority over every other input, including mid-operation with a full FIFO.
- Timestamp ts (internal, TS_W bits):
  - ts=0 in the first cycle after reset deasserts.
  - Increments by 1 each cycle en=1 and holds when en=0.
  - Wraps 2^TS_W-1 -> 0 with no flag.
- Hit = en & match, sampled at the edge. Each high cycle counts separately; back-to-back highs are separate hits. match is ignored when en=0.
- Counter: on a hit, count <= count+1, saturating at 2^CNT_W-1 and never wrapping.
- Push: on a hit, the current-cycle ts value (before its increment) is written to the FIFO tail.
- Pop: rd_en & ~empty advances the head. rd_en while empty is ignored and changes no state.
- FWFT output:
  - rd_data is the head entry, combinational from storage.
  - Entry written at edge N is visible on rd_data after edge N when the FIFO was empty (latency 1).
  - rd_data value when empty=1 is don't-care; the bench must not check it.
- Full handling:
  - Hit while full with no pop: entry dropped, count still increments, overflow <= 1.
  - Hit and pop in the same cycle while full: both take effect, occupancy stays DEPTH, no overflow.
  - Hit and pop in the same cycle while empty: push only; the pop is ignored.
- Sticky flag: overflow clears only on reset.
- Occupancy flags:
  - Occupancy is tracked with DEPTH-wide pointers plus a wrap bit (or an explicit occupancy counter).
  - empty = (occ==0), full = (occ==DEPTH), both registered-consistent with the pointers.
  - Pointers wrap modulo DEPTH.
- No state machine beyond the FIFO occupancy; no combinational path from match or rd_en to any output except rd_data via the head pointer.

Test Plan:
1. Basic capture (reset, then en=1, match=1 for one cycle at ts=5): next cycle empty=0, rd_data=8'd5, count=1. rd_en one cycle -> empty=1.
2. Overflow (hits at ts=10,12,14,16,18, no reads): full=1 after 4th hit; after 5th, count=5 and overflow=1. Popping 4 times yields 10,12,14,16, then empty=1.
3. Simultaneous push/pop when full (FIFO full with 10,12,14,16; rd_en=1 and hit at ts=20 same cycle): rd_data=12, full=1, overflow=0. Draining yields 12,14,16,20.
4. Saturation and enable gating:
   - 20 hits with continuous reads: count stops at 4'hF.
   - match=1 with en=0 for 3 cycles: count, ts and FIFO unchanged.
5. Timestamp wrap (en=1 for 258 cycles after reset, hit in cycle index 257): rd_data=8'd1. Empty-read: rd_en pulses while empty=1 leave state unchanged.
6. Reset mid-operation (FIFO full, overflow=1, count=9; reset=1 one cycle): next cycle empty=1, full=0, count=0, overflow=0, and the next hit stamps ts=0.
